// File: rtl/mem_pkg.sv
// Shared definitions for the memory-path blocks: write-FSM state encoding,
// AXI response code and word stride.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int unsigned WORD_STRIDE = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_stream_writer.sv
// Turns a command (start address, word count) plus a 32-bit word stream into
// single-beat AXI4-Lite writes, one outstanding transaction at a time.
module mem_stream_writer
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; a valid, once raised, holds with stable payload
    // until its ready is seen.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [31:0]           s_tdata,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            err_count,
    output logic [2:0]            dbg_state
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [7:0]            err_q, err_d;
    logic                  aw_ok, w_ok;
    logic                  unused_addr_lsbs;

    // Commands are always word aligned; the byte offset bits are dropped.
    assign unused_addr_lsbs = ^cmd_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        s_tready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        aw_ok     = 1'b0;
        w_ok      = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                    len_d   = cmd_len;
                    state_d = (cmd_len == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    wdata_d   = s_tdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // Address and data channels complete independently, in any order.
                m_awvalid = ~aw_done_q;
                m_wvalid  = ~w_done_q;
                aw_ok     = aw_done_q | m_awready;
                w_ok      = w_done_q | m_wready;
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY) begin
                        err_d = sat_inc8(err_q);
                    end
                    len_d   = len_q - LEN_WIDTH'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(WORD_STRIDE);
                    state_d = (len_q == LEN_WIDTH'(1)) ? FIN : FETCH;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_awaddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_awprot  = 3'b000;
    assign err_count = err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mem_stream_writer.md
MEM_STREAM_WRITER -- requirements
Module: mem_stream_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: byte-address width of the AXI4-Lite memory port it drives.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of the command word count.
REQ-003 SHALL have port clk, input, 1: the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_addr input ADDR_WIDTH, cmd_len input LEN_WIDTH: the command channel giving start byte address and word count.
REQ-006 SHALL have ports s_tvalid input 1, s_tready output 1, s_tdata input 32: the data word stream, one word per beat.
REQ-007 SHALL have AXI4-Lite write master ports m_awvalid out 1, m_awready in 1, m_awaddr out ADDR_WIDTH, m_awprot out 3, m_wvalid out 1, m_wready in 1, m_wdata out 32, m_wstrb out 4, m_bvalid in 1, m_bready out 1, m_bresp in 2, intended for the memory block's s_mem write channels.
REQ-008 SHALL have ports busy output 1, done output 1 (one-cycle pulse), err_count output 8 (saturating count of non-OKAY responses).

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, WRITE, RESP, FIN.
REQ-010 IDLE: cmd_ready=1; on cmd_valid, latch the address as {cmd_addr[ADDR_WIDTH-1:2], 2'b00} and latch cmd_len; go to FIN if cmd_len==0, else to FETCH.
REQ-011 FETCH: s_tready=1; on s_tvalid, register s_tdata into m_wdata and go to WRITE; no other handshake output is active.
REQ-012 WRITE: m_awvalid and m_wvalid SHALL rise in the same cycle and each SHALL stay high until its own ready is seen; the channels are tracked independently (aw_done, w_done flags); go to RESP in the cycle both are complete, including when both readies arrive together.
REQ-013 m_awaddr and m_wdata SHALL remain stable while the corresponding valid is high; m_wstrb SHALL be 4'hF and m_awprot 3'b000.
REQ-014 RESP: m_bready=1; on m_bvalid, if m_bresp!=2'b00, increment err_count, saturating at 255; decrement the remaining count; advance the address by 4 modulo 2^ADDR_WIDTH; go to FETCH if the remaining count is nonzero, else go to FIN.
REQ-015 Address wrap: the address after 2^ADDR_WIDTH-4 SHALL be 0, with no error.
REQ-016 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 At most one write transaction SHALL be outstanding; a new aw/w SHALL never be issued before the previous b handshake.
REQ-019 Latency: with all readies and s_tvalid held high, each word SHALL take 3 cycles (FETCH, WRITE, RESP); an N-word command SHALL assert done N*3+1 cycles after the command handshake.
REQ-020 err_count SHALL accumulate across commands and clear only on reset.

Reset
REQ-021 On a clock edge with reset=1, the FSM SHALL go to IDLE and err_count, the remaining count, the address register, m_wdata, aw_done and w_done SHALL be cleared.
REQ-022 Output reset values: cmd_ready=0 during reset and 1 in IDLE afterwards; s_tready=0, m_awvalid=0, m_wvalid=0, m_bready=0, busy=0, done=0, m_awaddr=0, m_wdata=0.
REQ-023 Reset mid-transaction SHALL drop all valids in the following cycle, without waiting for the slave's response.

Structure
REQ-024 The FSM state encoding, OKAY=2'b00 and the word stride of 4 SHALL be defined in a shared package (mem_pkg) for reuse by the other memory-path blocks.
REQ-025 The block SHALL be a single module with no sub-modules; the 8-bit saturating counter MAY be factored as sat_counter if reuse is needed.

Verification
REQ-026 cmd_addr=0x010, cmd_len=3, stream 0xA, 0xB, 0xC, all readies high -> writes to 0x010, 0x014, 0x018 with data 0xA, 0xB, 0xC; done 10 cycles after the command handshake; err_count=0.
REQ-027 m_awready delayed 3 cycles and m_wready immediate, then the reverse on the next word -> each valid holds until its own ready; exactly one aw and one w handshake per word.
REQ-028 ADDR_WIDTH=10, cmd_addr=0x3F8, cmd_len=4 -> addresses 0x3F8, 0x3FC, 0x000, 0x004.
REQ-029 m_bresp=2'b10 on 2 of 3 words -> err_count=2, all 3 writes complete, done pulses once; 300 SLVERR responses -> err_count=255.
REQ-030 cmd_len=0 -> no aw/w activity; done pulses 1 cycle after the handshake; busy=1 for that one cycle.
REQ-031 reset asserted while in WRITE with m_awready=0 -> next cycle m_awvalid=0, m_wvalid=0, busy=0, err_count=0; the next command behaves as from power-up.
